// File: rtl/scan_mux_decoder.sv
// Scanning channel multiplexer with one-hot decode and a single-entry sample holder.
// The channel pointer sel_cur is picked per mode: manual, step, auto and hold.
// y is a registered AND-OR mux of the selected channel.
// Each channel change offers one sample on a valid/ready port. If a sample is dropped,
// the sticky overrun flag is set.
// Build option: define SCAN_MUX_AUTO_EN to build the auto-scan dwell counter.
// Without SCAN_MUX_AUTO_EN, mode 2'b10 behaves as hold and DWELL has no effect.
module scan_mux_decoder #(
    parameter int  N_CH   = 4,
    parameter int  DATA_W = 1,
    parameter int  DWELL  = 1000,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [1:0]               mode,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic                     step,
    input  logic [N_CH*DATA_W-1:0]   data_in,
    output logic [N_CH-1:0]          dec_out,
    output logic [SEL_W-1:0]         sel_cur,
    output logic [DATA_W-1:0]        y,
    output logic                     smp_valid,
    input  logic                     smp_ready,
    output logic [SEL_W-1:0]         smp_ch,
    output logic [DATA_W-1:0]        smp_data,
    output logic                     overrun
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    if (N_CH < 2) begin : g_bad_n_ch
        $error("scan_mux_decoder: N_CH must be at least 2");
    end
    if (DWELL < 1) begin : g_bad_dwell
        $error("scan_mux_decoder: DWELL must be at least 1");
    end

    logic [SEL_W-1:0]  sel_cur_q, sel_cur_d, sel_adv;
    logic              step_q, step_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic              smp_valid_q, smp_valid_d;
    logic [SEL_W-1:0]  smp_ch_q, smp_ch_d;
    logic [DATA_W-1:0] smp_data_q, smp_data_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] nxt_data;
    logic              smp_evt;
    logic              sel_in_ok;

    // Out-of-range manual requests are only possible when N_CH is not a power of two.
    if ((1 << SEL_W) == N_CH) begin : g_full_range
        assign sel_in_ok = 1'b1;
    end else begin : g_part_range
        assign sel_in_ok = (sel_in <= LAST_CH);
    end

    assign sel_adv = (sel_cur_q == LAST_CH) ? '0 : sel_cur_q + 1'b1;

`ifdef SCAN_MUX_AUTO_EN
    localparam int              DW_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_TC = DW_W'(DWELL - 1);

    logic [DW_W-1:0] dwell_q, dwell_d;

    // Dwell timer: runs only in auto mode, so entering auto always gives a full period.
    always_comb begin
        dwell_d = '0;
        if (mode == 2'b10 && dwell_q != DWELL_TC) begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    // Dwell timer register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) dwell_q <= '0;
        else          dwell_q <= dwell_d;
    end
`endif

    // Next channel selection per mode; the step edge detector tracks step in every mode.
    always_comb begin
        sel_cur_d = sel_cur_q;
        step_d    = step;
        case (mode)
            2'b00:   if (sel_in_ok) sel_cur_d = sel_in;
            2'b01:   if (step && !step_q) sel_cur_d = sel_adv;
`ifdef SCAN_MUX_AUTO_EN
            2'b10:   if (dwell_q == DWELL_TC) sel_cur_d = sel_adv;
`endif
            default: sel_cur_d = sel_cur_q;
        endcase
    end

    // One-hot decode of the current channel.
    always_comb begin
        dec_out            = '0;
        dec_out[sel_cur_q] = 1'b1;
    end

    // AND-OR mux of the current channel, registered into y.
    always_comb begin
        y_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            y_d = y_d | (data_in[i*DATA_W +: DATA_W] & {DATA_W{dec_out[i]}});
        end
    end

    // Slice of the channel being switched to, captured as the new sample.
    always_comb begin
        nxt_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel_cur_d == SEL_W'(i)) nxt_data = data_in[i*DATA_W +: DATA_W];
        end
    end

    assign smp_evt = (sel_cur_d != sel_cur_q);

    // Single-entry sample holder. A new sample is taken only when the slot is free
    // or is being consumed this cycle; otherwise the sample is dropped and flagged.
    always_comb begin
        smp_valid_d = smp_valid_q;
        smp_ch_d    = smp_ch_q;
        smp_data_d  = smp_data_q;
        overrun_d   = overrun_q;
        if (smp_evt) begin
            if (!smp_valid_q || smp_ready) begin
                smp_valid_d = 1'b1;
                smp_ch_d    = sel_cur_d;
                smp_data_d  = nxt_data;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (smp_valid_q && smp_ready) begin
            smp_valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_cur_q   <= '0;
            step_q      <= 1'b0;
            y_q         <= '0;
            smp_valid_q <= 1'b0;
            smp_ch_q    <= '0;
            smp_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            sel_cur_q   <= sel_cur_d;
            step_q      <= step_d;
            y_q         <= y_d;
            smp_valid_q <= smp_valid_d;
            smp_ch_q    <= smp_ch_d;
            smp_data_q  <= smp_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sel_cur   = sel_cur_q;
    assign y         = y_q;
    assign smp_valid = smp_valid_q;
    assign smp_ch    = smp_ch_q;
    assign smp_data  = smp_data_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_scan_mux_decoder.sv
// Testbench for scan_mux_decoder.
// A cycle model runs beside the DUT. Samples are scoreboarded: each sample the model
// expects is queued, then popped and compared when the DUT hands a sample over.
// Auto-mode expectations follow SCAN_MUX_AUTO_EN.
module tb_scan_mux_decoder;

    localparam int N_CH   = 4;
    localparam int DATA_W = 3;
    localparam int DWELL  = 3;
    localparam int SEL_W  = 2;

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b0;
    logic [1:0]             mode = 2'b00;
    logic [SEL_W-1:0]       sel_in = '0;
    logic                   step = 1'b0;
    logic [N_CH*DATA_W-1:0] data_in = '0;
    logic [N_CH-1:0]        dec_out;
    logic [SEL_W-1:0]       sel_cur;
    logic [DATA_W-1:0]      y;
    logic                   smp_valid;
    logic                   smp_ready = 1'b0;
    logic [SEL_W-1:0]       smp_ch;
    logic [DATA_W-1:0]      smp_data;
    logic                   overrun;

    scan_mux_decoder #(.N_CH(N_CH), .DATA_W(DATA_W), .DWELL(DWELL)) dut (
        .clock(clock), .reset_n(reset_n), .mode(mode), .sel_in(sel_in), .step(step),
        .data_in(data_in), .dec_out(dec_out), .sel_cur(sel_cur), .y(y),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_ch(smp_ch),
        .smp_data(smp_data), .overrun(overrun)
    );

    always #5 clock = ~clock;

`ifdef SCAN_MUX_AUTO_EN
    localparam bit AUTO_ON = 1'b1;
`else
    localparam bit AUTO_ON = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [SEL_W-1:0]  m_sel;
    logic              m_stepq;
    int                m_dwell;
    logic [DATA_W-1:0] m_y;
    logic              m_valid;
    logic [SEL_W-1:0]  m_ch;
    logic [DATA_W-1:0] m_data;
    logic              m_ovr;
    logic [SEL_W+DATA_W-1:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] slice(input logic [N_CH*DATA_W-1:0] d, input int idx);
        return d[idx*DATA_W +: DATA_W];
    endfunction

    function automatic logic [SEL_W-1:0] adv(input logic [SEL_W-1:0] s);
        return SEL_W'((int'(s) + 1) % N_CH);
    endfunction

    task automatic model_reset();
        m_sel = '0; m_stepq = 1'b0; m_dwell = 0; m_y = '0;
        m_valid = 1'b0; m_ch = '0; m_data = '0; m_ovr = 1'b0;
        sb_q.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"},   32'(sel_cur),   32'd0);
        chk({tag, "_dec"},   32'(dec_out),   32'd1);
        chk({tag, "_y"},     32'(y),         32'd0);
        chk({tag, "_valid"}, 32'(smp_valid), 32'd0);
        chk({tag, "_ch"},    32'(smp_ch),    32'd0);
        chk({tag, "_data"},  32'(smp_data),  32'd0);
        chk({tag, "_ovr"},   32'(overrun),   32'd0);
    endtask

    // One clock: predict from current inputs, consume any handed-over sample, then compare.
    task automatic cycle();
        logic [SEL_W-1:0]        nsel;
        int                      ndw;
        logic                    n_valid, n_ovr, push;
        logic [SEL_W-1:0]        n_ch;
        logic [DATA_W-1:0]       n_data, n_y;
        logic [SEL_W+DATA_W-1:0] exp_s;
        nsel = m_sel;
        ndw  = 0;
        case (mode)
            2'b00: nsel = sel_in;
            2'b01: if (step && !m_stepq) nsel = adv(m_sel);
            2'b10: if (AUTO_ON) begin
                       if (m_dwell == DWELL - 1) nsel = adv(m_sel);
                       else ndw = m_dwell + 1;
                   end
            default: ;
        endcase
        n_y = slice(data_in, int'(m_sel));
        n_valid = m_valid; n_ch = m_ch; n_data = m_data; n_ovr = m_ovr; push = 1'b0;
        if (nsel != m_sel) begin
            if (!m_valid || smp_ready) begin
                n_valid = 1'b1; n_ch = nsel; n_data = slice(data_in, int'(nsel)); push = 1'b1;
            end else begin
                n_ovr = 1'b1;
            end
        end else if (m_valid && smp_ready) begin
            n_valid = 1'b0;
        end
        if (smp_valid && smp_ready) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_s = sb_q.pop_front();
                chk("sb_ch",   32'(smp_ch),   32'(exp_s[SEL_W+DATA_W-1:DATA_W]));
                chk("sb_data", 32'(smp_data), 32'(exp_s[DATA_W-1:0]));
            end
        end
        @(posedge clock);
        #1;
        m_stepq = step; m_sel = nsel; m_dwell = ndw; m_y = n_y;
        m_valid = n_valid; m_ch = n_ch; m_data = n_data; m_ovr = n_ovr;
        if (push) sb_q.push_back({n_ch, n_data});
        chk("sel_cur",   32'(sel_cur),   32'(m_sel));
        chk("dec_out",   32'(dec_out),   32'd1 << m_sel);
        chk("y",         32'(y),         32'(m_y));
        chk("smp_valid", 32'(smp_valid), 32'(m_valid));
        chk("smp_ch",    32'(smp_ch),    32'(m_ch));
        chk("smp_data",  32'(smp_data),  32'(m_data));
        chk("overrun",   32'(overrun),   32'(m_ovr));
    endtask

    initial begin
        logic [SEL_W-1:0] step_seq [5];
        step_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        model_reset();
        #2;
        chk_reset_vals("por");
        @(negedge clock);
        reset_n = 1'b1;

        // Manual scan over a pattern with only channel 2 non-zero.
        data_in = {3'b000, 3'b101, 3'b000, 3'b000};
        smp_ready = 1'b1;
        mode = 2'b00;
        for (int s = 0; s < N_CH; s++) begin
            sel_in = SEL_W'(s);
            cycle();
            chk("man_dec", 32'(dec_out), 32'd1 << s);
            cycle();
        end

        // Step mode: five pulses, then a long level that must advance only once.
        sel_in = '0;
        cycle();
        mode = 2'b01;
        for (int k = 0; k < 5; k++) begin
            step = 1'b1; data_in = N_CH*DATA_W'($urandom);
            cycle();
            chk("step_seq", 32'(sel_cur), 32'(step_seq[k]));
            step = 1'b0;
            cycle();
        end
        step = 1'b1;
        for (int k = 0; k < 10; k++) cycle();
        chk("step_level", 32'(sel_cur), 32'd2);
        step = 1'b0;

        // Auto mode from channel 0 with a freshly cleared dwell timer.
        mode = 2'b00; sel_in = '0;
        cycle();
        mode = 2'b10;
        for (int k = 1; k <= 12; k++) begin
            data_in = N_CH*DATA_W'($urandom);
            cycle();
            chk("auto_sel", 32'(sel_cur), AUTO_ON ? 32'((k / DWELL) % N_CH) : 32'd0);
        end

        // Stalled consumer: first sample held, second dropped with overrun.
        mode = 2'b00; sel_in = 2'd1; smp_ready = 1'b1;
        cycle();
        mode = 2'b11;
        cycle();
        mode = 2'b00; smp_ready = 1'b0; sel_in = 2'd2;
        cycle();
        sel_in = 2'd3;
        cycle();
        chk("ovr_ch",    32'(smp_ch),    32'd2);
        chk("ovr_valid", 32'(smp_valid), 32'd1);
        chk("ovr_flag",  32'(overrun),   32'd1);
        mode = 2'b11; smp_ready = 1'b1;
        cycle();
        chk("ovr_drain", 32'(smp_valid), 32'd0);
        chk("ovr_stick", 32'(overrun),   32'd1);

        // Back-to-back events with a ready consumer keep smp_valid high.
        mode = 2'b00;
        for (int s = 0; s < 3; s++) begin
            sel_in = SEL_W'(s); data_in = N_CH*DATA_W'($urandom);
            cycle();
            chk("no_gap", 32'(smp_valid), 32'd1);
        end

        // Asynchronous reset between edges during auto with a sample pending.
        smp_ready = 1'b0; mode = 2'b10;
        for (int k = 0; k < 4; k++) cycle();
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        cycle();
        chk("rst_no_smp", 32'(smp_valid), 32'd0);
        for (int k = 0; k < 6; k++) cycle();

        // Random traffic with sticky modes so auto dwell periods can complete.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            sel_in    = SEL_W'($urandom);
            step      = 1'($urandom);
            smp_ready = ($urandom_range(0, 3) != 0);
            data_in   = N_CH*DATA_W'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
